// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its command sequencer:
// opcode encoding, sequencer FSM states and default widths.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int OP_W_DEFAULT   = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_INCA = 4'h8,
        OP_DECA = 4'h9,
        OP_XOR  = 4'hA,
        OP_SHR  = 4'hB,
        OP_SHL  = 4'hC,
        OP_ADDC = 4'hD,
        OP_SUBB = 4'hE,
        OP_INCB = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU driven by alu_cmd_seq; results wrap to DATA_W bits.
// Divide by zero yields all ones; ADDC/SUBB fold in a constant carry/borrow of one.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int OP_W   = OP_W_DEFAULT
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [DATA_W-1:0] y_o
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    // NOTE: y_o gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        y_o = '0;
        case (op_i)
            OP_W'(OP_ADD):  y_o = a_i + b_i;
            OP_W'(OP_SUB):  y_o = a_i - b_i;
            OP_W'(OP_MUL):  y_o = a_i * b_i;
            OP_W'(OP_DIV):  y_o = (b_i == '0) ? '1 : a_i / b_i;
            OP_W'(OP_AND):  y_o = a_i & b_i;
            OP_W'(OP_OR):   y_o = a_i | b_i;
            OP_W'(OP_NAND): y_o = ~(a_i & b_i);
            OP_W'(OP_NOR):  y_o = ~(a_i | b_i);
            OP_W'(OP_INCA): y_o = a_i + ONE;
            OP_W'(OP_DECA): y_o = a_i - ONE;
            OP_W'(OP_XOR):  y_o = a_i ^ b_i;
            OP_W'(OP_SHR):  y_o = a_i >> 1;
            OP_W'(OP_SHL):  y_o = a_i << 1;
            OP_W'(OP_ADDC): y_o = a_i + b_i + ONE;
            OP_W'(OP_SUBB): y_o = a_i - b_i - ONE;
            OP_W'(OP_INCB): y_o = b_i + ONE;
            default:        y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Valid/ready command sequencer in front of a combinational ALU, with a result accumulator.
// Optional divide-by-zero trapping is enabled by defining ALU_SEQ_DIVZERO_CHK_EN.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int OP_W   = OP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] acc
);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] acc_q, acc_d;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    logic              rsp_err_q, rsp_err_d;
    logic              div0_q, div0_d;
`endif

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        acc_d      = acc_q;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        rsp_err_d  = rsp_err_q;
        div0_d     = div0_q;
`endif
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
                    // The ALU ports still load on a trapped divide; only the capture differs.
                    div0_d   = (cmd_op == OP_W'(OP_DIV)) && (cmd_b == '0);
`endif
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
`ifdef ALU_SEQ_DIVZERO_CHK_EN
                if (div0_q) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    rsp_data_d = alu_out;
                    rsp_err_d  = 1'b0;
                    acc_d      = alu_out;
                end
`else
                rsp_data_d = alu_out;
                acc_d      = alu_out;
`endif
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            acc_q      <= '0;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
            rsp_err_q  <= 1'b0;
            div0_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            acc_q      <= acc_d;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
            rsp_err_q  <= rsp_err_d;
            div0_q     <= div0_d;
`endif
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_data = rsp_data_q;
    assign acc      = acc_q;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    assign rsp_err  = rsp_err_q;
`else
    assign rsp_err  = 1'b0;
`endif

endmodule
